// File: rtl/scan_ctrl_pkg.sv
// Shared types and defaults for the scan-chain frame controller.
package scan_ctrl_pkg;
    localparam int WORD_W_DEF    = 26;
    localparam int NUM_WORDS_DEF = 256;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FREEZE = 3'd1;
    localparam state_t ST_SHIFT  = 3'd2;
    localparam state_t ST_STALL  = 3'd3;
    localparam state_t ST_DRAIN  = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/scan_deser.sv
// Dual LSB-first shift accumulator for the X/W chains with a word-complete strobe.
module scan_deser
    import scan_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              mux_clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift,
    input  logic              bit_x,
    input  logic              bit_w,
    output logic [WORD_W-1:0] word_x,
    output logic [WORD_W-1:0] word_w,
    output logic              word_done
);
    localparam int BIT_W = idx_w(WORD_W);
    localparam logic [BIT_W-1:0] LAST = BIT_W'(WORD_W - 1);

    logic [BIT_W-1:0]  bit_idx;
    logic [WORD_W-1:0] acc_x, acc_w;

    assign word_done = shift && (bit_idx == LAST);

    // The MSB arrives on the completing edge, so merge it in combinationally.
    always_comb begin
        word_x = acc_x;
        word_w = acc_w;
        word_x[WORD_W-1] = bit_x;
        word_w[WORD_W-1] = bit_w;
    end

    always_ff @(posedge mux_clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
            acc_x   <= '0;
            acc_w   <= '0;
        end else if (clr) begin
            bit_idx <= '0;
        end else if (shift) begin
            acc_x[bit_idx] <= bit_x;
            acc_w[bit_idx] <= bit_w;
            bit_idx <= word_done ? '0 : bit_idx + BIT_W'(1);
        end
    end
endmodule

// File: rtl/scan_frame_ctrl.sv
// Scan-chain frame sequencer: freeze, shift, deserialise, stream words with backpressure.
// Optional SCAN_CTRL_AUTO_EN adds a periodic self-trigger after AUTO_PERIOD idle cycles.
module scan_frame_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int NUM_WORDS   = NUM_WORDS_DEF,
`ifdef SCAN_CTRL_AUTO_EN
    parameter int AUTO_PERIOD = 1000000,
`endif
    parameter int FREEZE_LAT  = 2
) (
    input  logic                         mux_clk,
    input  logic                         rst_n,
    input  logic                         scan_start,
    input  logic                         scan_abort,
    input  logic                         scan_out_x,
    input  logic                         scan_out_w,
    output logic                         scan_en,
    output logic                         scan_freeze,
    output logic [WORD_W-1:0]            wd_x,
    output logic [WORD_W-1:0]            wd_w,
    output logic [idx_w(NUM_WORDS)-1:0]  wd_idx,
    output logic                         wd_vld,
    input  logic                         wd_rdy,
    output logic                         busy,
    output logic                         frame_done
);
    localparam int IDX_W = idx_w(NUM_WORDS);
    localparam int FL_W  = idx_w(FREEZE_LAT);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FREEZE_LAT - 1);

    state_t            state;
    logic [FL_W-1:0]   fcnt;
    logic [IDX_W-1:0]  idx;
    logic              out_vld, pend_vld;
    logic [WORD_W-1:0] pend_x, pend_w;
    logic [IDX_W-1:0]  pend_idx;
    logic [WORD_W-1:0] word_x, word_w;
    logic              word_done, hs, start_go;

    scan_deser #(.WORD_W(WORD_W)) u_deser (
        .mux_clk   (mux_clk),
        .rst_n     (rst_n),
        .clr       (scan_abort),
        .shift     (scan_en),
        .bit_x     (scan_out_x),
        .bit_w     (scan_out_w),
        .word_x    (word_x),
        .word_w    (word_w),
        .word_done (word_done)
    );

    assign hs          = out_vld && wd_rdy;
    assign wd_vld      = out_vld;
    assign busy        = (state != ST_IDLE);
    assign scan_freeze = busy;
    assign frame_done  = (state == ST_DONE);

`ifdef SCAN_CTRL_AUTO_EN
    localparam int AC_W = idx_w(AUTO_PERIOD);
    logic [AC_W-1:0] idle_cnt;
    logic            auto_go;

    assign auto_go  = (state == ST_IDLE) && (idle_cnt == AC_W'(AUTO_PERIOD - 1));
    assign start_go = scan_start || auto_go;

    always_ff @(posedge mux_clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (scan_abort || state != ST_IDLE || start_go)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + AC_W'(1);
    end
`else
    assign start_go = scan_start;
`endif

    always_ff @(posedge mux_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fcnt     <= '0;
            idx      <= '0;
            scan_en  <= 1'b0;
            out_vld  <= 1'b0;
            pend_vld <= 1'b0;
            wd_x     <= '0;
            wd_w     <= '0;
            wd_idx   <= '0;
            pend_x   <= '0;
            pend_w   <= '0;
            pend_idx <= '0;
        end else if (scan_abort) begin
            state    <= ST_IDLE;
            scan_en  <= 1'b0;
            out_vld  <= 1'b0;
            pend_vld <= 1'b0;
        end else begin
            if (hs) out_vld <= 1'b0;
            case (state)
                ST_IDLE: if (start_go) begin
                    state <= ST_FREEZE;
                    fcnt  <= '0;
                    idx   <= IDX_W'(NUM_WORDS - 1);
                end
                ST_FREEZE: if (fcnt == FL_LAST) begin
                    state   <= ST_SHIFT;
                    scan_en <= 1'b1;
                end else begin
                    fcnt <= fcnt + FL_W'(1);
                end
                ST_SHIFT: if (word_done) begin
                    if (!out_vld || hs) begin
                        wd_x    <= word_x;
                        wd_w    <= word_w;
                        wd_idx  <= idx;
                        out_vld <= 1'b1;
                    end else begin
                        pend_x   <= word_x;
                        pend_w   <= word_w;
                        pend_idx <= idx;
                        pend_vld <= 1'b1;
                    end
                    // The last word goes straight to DRAIN even if it landed in pend.
                    if (idx == '0) begin
                        state   <= ST_DRAIN;
                        scan_en <= 1'b0;
                    end else begin
                        idx <= idx - IDX_W'(1);
                        if (out_vld && !hs) begin
                            state   <= ST_STALL;
                            scan_en <= 1'b0;
                        end
                    end
                end
                ST_STALL: if (hs) begin
                    wd_x     <= pend_x;
                    wd_w     <= pend_w;
                    wd_idx   <= pend_idx;
                    out_vld  <= 1'b1;
                    pend_vld <= 1'b0;
                    scan_en  <= 1'b1;
                    state    <= ST_SHIFT;
                end
                ST_DRAIN: if (hs && pend_vld) begin
                    wd_x     <= pend_x;
                    wd_w     <= pend_w;
                    wd_idx   <= pend_idx;
                    out_vld  <= 1'b1;
                    pend_vld <= 1'b0;
                end else if (!pend_vld && (!out_vld || hs)) begin
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_frame_ctrl.sv
// Directed bench for scan_frame_ctrl: chain model feeds patterned words, scoreboard checks the stream.
module tb_scan_frame_ctrl;
    localparam int WORD_W     = 26;
    localparam int NUM_WORDS  = 256;
    localparam int IDX_W      = 8;
    localparam int FREEZE_LAT = 2;

    logic mux_clk = 1'b0;
    logic rst_n = 1'b0, scan_start = 1'b0, scan_abort = 1'b0, wd_rdy = 1'b0;
    logic scan_out_x, scan_out_w;
    logic scan_en, scan_freeze, wd_vld, busy, frame_done;
    logic [WORD_W-1:0] wd_x, wd_w;
    logic [IDX_W-1:0]  wd_idx;

    int n_tests = 0, n_fail = 0;

    always #5 mux_clk = ~mux_clk;

    scan_frame_ctrl #(
        .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS),
`ifdef SCAN_CTRL_AUTO_EN
        .AUTO_PERIOD(50),
`endif
        .FREEZE_LAT(FREEZE_LAT)
    ) dut (
        .mux_clk(mux_clk), .rst_n(rst_n), .scan_start(scan_start), .scan_abort(scan_abort),
        .scan_out_x(scan_out_x), .scan_out_w(scan_out_w), .scan_en(scan_en),
        .scan_freeze(scan_freeze), .wd_x(wd_x), .wd_w(wd_w), .wd_idx(wd_idx),
        .wd_vld(wd_vld), .wd_rdy(wd_rdy), .busy(busy), .frame_done(frame_done)
    );

    function automatic logic [WORD_W-1:0] pat_x(input logic [IDX_W-1:0] k);
        return 26'h2AAAAAA ^ WORD_W'(k);
    endfunction
    function automatic logic [WORD_W-1:0] pat_w(input logic [IDX_W-1:0] k);
        return 26'h1555555 ^ {k[3:0], 14'h0, k};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Chain model: presents bit ch_bit of word ch_word; pushes each fully shifted word.
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [WORD_W-1:0] x;
        logic [WORD_W-1:0] w;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    logic [IDX_W-1:0]  ch_word = IDX_W'(NUM_WORDS - 1);
    logic [4:0]        ch_bit = '0;
    logic [WORD_W-1:0] cx, cw;
    always_comb begin
        cx = pat_x(ch_word);
        cw = pat_w(ch_word);
    end
    assign scan_out_x = cx[ch_bit];
    assign scan_out_w = cw[ch_bit];

    always @(posedge mux_clk) begin
        if (!busy) begin
            ch_word <= IDX_W'(NUM_WORDS - 1);
            ch_bit  <= '0;
        end else if (scan_en) begin
            if (ch_bit == 5'(WORD_W - 1)) begin
                sb.push_back({ch_word, cx, cw});
                ch_bit  <= '0;
                ch_word <= ch_word - 1'b1;
            end else begin
                ch_bit <= ch_bit + 1'b1;
            end
        end
    end

    // Monitor: scoreboard pops, hold stability, throughput gaps, running totals.
    int gcyc = 0, last_hs = -1, pops = 0, en_total = 0, frz_total = 0, done_total = 0;
    bit chk_gap = 1'b0;
    logic stalled = 1'b0;
    logic [IDX_W+2*WORD_W-1:0] held = '0;

    always @(posedge mux_clk) gcyc <= gcyc + 1;

    always @(negedge mux_clk) begin
        if (rst_n) begin
            en_total   <= en_total + int'(scan_en);
            frz_total  <= frz_total + int'(scan_freeze);
            done_total <= done_total + int'(frame_done);
            if (stalled)
                check("hold", 64'({wd_vld, wd_idx, wd_x, wd_w}), 64'({1'b1, held}));
            stalled <= wd_vld && !wd_rdy;
            held    <= {wd_idx, wd_x, wd_w};
            if (wd_vld && wd_rdy) begin
                if (sb.size() == 0) begin
                    check("sb_depth", 64'(sb.size() > 0), 64'(1));
                end else begin
                    e = sb.pop_front();
                    check("word", 64'({wd_idx, wd_x, wd_w}), 64'(e));
                end
                pops <= pops + 1;
                if (chk_gap && last_hs >= 0) check("gap", 64'(gcyc - last_hs), 64'(WORD_W));
                last_hs <= gcyc;
            end
            if (!busy) last_hs <= -1;
        end
    end

    int b_pop, b_en, b_frz, b_done, cyc, en_cnt, idle;

    task automatic snap();
        b_pop = pops; b_en = en_total; b_frz = frz_total; b_done = done_total;
    endtask

    task automatic pulse_start();
        @(negedge mux_clk) scan_start = 1'b1;
        @(posedge mux_clk); #1 scan_start = 1'b0;
    endtask

    task automatic wait_idx(input int k);
        for (int i = 0; i < 8000 && !(wd_vld && wd_idx == IDX_W'(k)); i++) begin
            @(posedge mux_clk); #1;
        end
        check("wait_idx", 64'({wd_vld, wd_idx}), 64'({1'b1, IDX_W'(k)}));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 8000 && !frame_done; i++) begin
            @(posedge mux_clk); #1;
        end
        check("frame_done", 64'(frame_done), 64'(1));
        @(posedge mux_clk); #1;
        check("idle_after_done", 64'({busy, scan_freeze, scan_en, wd_vld}), 64'(0));
    endtask

    task automatic frame_totals(input string tag);
        check({tag, "_pops"}, 64'(pops - b_pop), 64'(NUM_WORDS));
        check({tag, "_done"}, 64'(done_total - b_done), 64'(1));
        check({tag, "_sb"}, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        repeat (3) @(posedge mux_clk);
        #1;
        check("rst_ctrl", 64'({scan_en, scan_freeze, wd_vld, busy, frame_done}), 64'(0));
        check("rst_data", 64'({wd_x, wd_w, wd_idx}), 64'(0));
        rst_n = 1'b1; wd_rdy = 1'b1; chk_gap = 1'b1;
        repeat (2) @(posedge mux_clk);
        #1;

        // Full frame at full throughput: latency, order, freeze span, no shift gaps
        snap();
        pulse_start();
        cyc = 1;
        check("start_outs", 64'({busy, scan_freeze, scan_en}), 64'(3'b110));
        while (!wd_vld && cyc < 100) begin
            @(posedge mux_clk); #1 cyc++;
        end
        check("first_vld_cycle", 64'(cyc), 64'(FREEZE_LAT + WORD_W + 1));
        check("first_idx", 64'(wd_idx), 64'(NUM_WORDS - 1));
        wait_done();
        frame_totals("f1");
        check("f1_shift_cycles", 64'(en_total - b_en), 64'(NUM_WORDS * WORD_W));
        check("f1_freeze_cycles", 64'(frz_total - b_frz), 64'(FREEZE_LAT + NUM_WORDS * WORD_W + 2));

        // Backpressure at word 10: hold, pend capture of word 11, chain paused
        chk_gap = 1'b0;
        snap();
        pulse_start();
        wait_idx(NUM_WORDS - 1 - 10);
        wd_rdy = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            en_cnt += int'(scan_en);
            @(posedge mux_clk); #1;
        end
        check("stall_en_cycles", 64'(en_cnt), 64'(WORD_W));
        check("stall_state", 64'({wd_vld, wd_idx, scan_en, busy}), 64'({1'b1, IDX_W'(245), 1'b0, 1'b1}));
        wd_rdy = 1'b1;
        @(posedge mux_clk); #1;
        check("release", 64'({wd_vld, wd_idx, scan_en}), 64'({1'b1, IDX_W'(244), 1'b1}));
        wait_done();
        frame_totals("f2");

        // Abort mid-word after word 100, then a clean full frame
        chk_gap = 1'b1;
        snap();
        pulse_start();
        wait_idx(NUM_WORDS - 1 - 100);
        repeat (7) @(posedge mux_clk);
        #1 scan_abort = 1'b1;
        @(posedge mux_clk); #1 scan_abort = 1'b0;
        check("abort_outs", 64'({scan_en, scan_freeze, wd_vld, busy}), 64'(0));
        repeat (5) @(posedge mux_clk);
        #1;
        check("abort_no_done", 64'(done_total - b_done), 64'(0));
        sb.delete();
        snap();
        pulse_start();
        wait_idx(NUM_WORDS - 1);
        wait_done();
        frame_totals("f3");

        // Start held high: one frame, retrigger only after DONE; abort beats start
        snap();
        @(negedge mux_clk) scan_start = 1'b1;
        wait_done();
        frame_totals("f4");
        @(posedge mux_clk); #1;
        check("retrigger", 64'({busy, scan_freeze}), 64'(2'b11));
        repeat (10) @(posedge mux_clk);
        #1 scan_abort = 1'b1;
        @(posedge mux_clk); #1;
        check("abort_beats_start_busy", 64'(busy), 64'(0));
        @(posedge mux_clk); #1;
        check("abort_beats_start_idle", 64'(busy), 64'(0));
        scan_abort = 1'b0; scan_start = 1'b0;
        @(posedge mux_clk); #1;
        check("idle_after_abort", 64'(busy), 64'(0));
        sb.delete();

`ifdef SCAN_CTRL_AUTO_EN
        for (int i = 0; i < 200 && !busy; i++) begin
            @(posedge mux_clk); #1;
        end
        check("auto_start", 64'(busy), 64'(1));
        wait_done();
        idle = 1;
        while (!busy && idle < 200) begin
            @(posedge mux_clk); #1;
            if (!busy) idle++;
        end
        check("auto_period", 64'(idle), 64'(50));
`else
        idle = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge mux_clk); #1;
            idle += int'(busy);
        end
        check("no_auto_start", 64'(idle), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
